alu_seq_core: RTL

//  Parametrised, handshaked successor to the 19-bit combinational ALU.

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_iter_muldiv.sv | 107 ++++++++++
 rtl/alu_seq_core.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU core.
//
// Contents:
//   OPC_W       opcode width
//   OP_*        opcode encodings (OP_ADD .. OP_CLRACC)
//   alu_state_e control FSM states of alu_seq_core
package alu_pkg;

    localparam int unsigned OPC_W = 5;

    // Single-cycle arithmetic / logic
    localparam logic [OPC_W-1:0] OP_ADD    = 5'b00000;
    localparam logic [OPC_W-1:0] OP_SUB    = 5'b00001;
    localparam logic [OPC_W-1:0] OP_AND    = 5'b00100;
    localparam logic [OPC_W-1:0] OP_OR     = 5'b00101;
    localparam logic [OPC_W-1:0] OP_XOR    = 5'b00110;
    localparam logic [OPC_W-1:0] OP_NOT    = 5'b00111;
    localparam logic [OPC_W-1:0] OP_ABS    = 5'b01010;
    localparam logic [OPC_W-1:0] OP_AVG    = 5'b01011;
    localparam logic [OPC_W-1:0] OP_INC    = 5'b01100;
    localparam logic [OPC_W-1:0] OP_DEC    = 5'b01101;
    localparam logic [OPC_W-1:0] OP_EQ     = 5'b01110;
    localparam logic [OPC_W-1:0] OP_NE     = 5'b01111;
    localparam logic [OPC_W-1:0] OP_ADDI   = 5'b10000;
    localparam logic [OPC_W-1:0] OP_SUBI   = 5'b10001;
    localparam logic [OPC_W-1:0] OP_ANDI   = 5'b10010;
    localparam logic [OPC_W-1:0] OP_ORI    = 5'b10011;
    localparam logic [OPC_W-1:0] OP_CLRACC = 5'b10100;

    // Iterative (one bit per cycle)
    localparam logic [OPC_W-1:0] OP_MUL    = 5'b00010;
    localparam logic [OPC_W-1:0] OP_DIV    = 5'b00011;
    localparam logic [OPC_W-1:0] OP_MAC    = 5'b01000;
    localparam logic [OPC_W-1:0] OP_SQR    = 5'b01001;

    // StDone: single-cycle op captured, result written on the next edge.
    // StMul / StDiv: iterator running, result written on the edge after done.
    typedef enum logic [1:0] {
        StIdle,
        StDone,
        StMul,
        StDiv
    } alu_state_e;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiplier / restoring divider, one bit per cycle.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset (aborts any operation)
//   start     load operands and begin; a/b/mode_div sampled on this edge
//   mode_div  0: multiply a*b (low DATA_W bits), 1: divide a/b (b != 0)
//   a, b      operands (multiplicand/multiplier or dividend/divisor)
//   done      high for one cycle once DATA_W steps have completed
//   res       product low half or quotient; valid while done is high
module alu_iter_muldiv #(
    parameter int unsigned DATA_W = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode_div,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] res
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    // Multiply: x = shifting multiplicand, y = shifting multiplier, z = partial product.
    // Divide:   x = divisor, y = dividend shifting out / quotient shifting in, z = remainder.
    logic [DATA_W-1:0] x_q, x_d;
    logic [DATA_W-1:0] y_q, y_d;
    logic [DATA_W-1:0] z_q, z_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              run_q, run_d;
    logic              div_q, div_d;

    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   diff;

    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        z_d   = z_q;
        cnt_d = cnt_q;
        run_d = run_q;
        div_d = div_q;

        // Restoring step: bring in the next dividend bit and trial-subtract.
        shifted = {z_q, y_q[DATA_W-1]};
        diff    = shifted - {1'b0, x_q};

        if (start) begin
            run_d = 1'b1;
            div_d = mode_div;
            cnt_d = CNT_W'(DATA_W);
            z_d   = '0;
            if (mode_div) begin
                x_d = b;
                y_d = a;
            end else begin
                x_d = a;
                y_d = b;
            end
        end else if (run_q) begin
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
                if (div_q) begin
                    // diff[DATA_W] set means the trial went negative: restore.
                    if (diff[DATA_W]) begin
                        z_d = shifted[DATA_W-1:0];
                    end else begin
                        z_d = diff[DATA_W-1:0];
                    end
                    y_d = {y_q[DATA_W-2:0], ~diff[DATA_W]};
                end else begin
                    if (y_q[0]) begin
                        z_d = z_q + x_q;
                    end
                    x_d = x_q << 1;
                    y_d = y_q >> 1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q   <= '0;
            y_q   <= '0;
            z_q   <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
            div_q <= 1'b0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            z_q   <= z_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
            div_q <= div_d;
        end
    end

    assign done = run_q && (cnt_q == '0);
    assign res  = div_q ? y_q : z_q;

endmodule

// File: rtl/alu_seq_core.sv
// Handshaked sequential ALU: single-cycle logic/add ops, iterative MUL/SQR/MAC/DIV,
// registered MAC accumulator and status flags.
//
// Configuration macro: ALU_SAT_EN
//   defined   - ADD/SUB/ADDI/SUBI/INC/DEC/MAC saturate as signed; flag_v port present
//   undefined - all arithmetic wraps modulo 2^DATA_W; no flag_v port
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready  operation handshake; opcode/op1/op2/immediate captured on accept
//   opcode, op1, op2     operation select and operands
//   immediate            IMM_W-bit immediate, sign-extended for *I ops
//   out_valid/out_ready  result handshake; result and flags held until taken
//   result               registered result
//   flag_z, flag_n       result is zero / result sign bit
//   flag_dz              division by zero produced this result
//   flag_v               (ALU_SAT_EN only) result was clamped
//   busy                 iterative operation in progress
module alu_seq_core #(
    parameter int unsigned DATA_W = 19,
    parameter int unsigned IMM_W  = 10,
    parameter int unsigned OPC_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    input  logic [IMM_W-1:0]  immediate,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_dz,
`ifdef ALU_SAT_EN
    output logic              flag_v,
`endif
    output logic              busy
);

    import alu_pkg::*;

    // Wrapping or (with ALU_SAT_EN) signed-saturating add/subtract.
`ifdef ALU_SAT_EN
    function automatic logic [DATA_W:0] ext_sum(input logic [DATA_W-1:0] x,
                                                 input logic [DATA_W-1:0] y,
                                                 input logic              sub);
        logic [DATA_W:0] xe;
        logic [DATA_W:0] ye;
        xe = {x[DATA_W-1], x};
        ye = {y[DATA_W-1], y};
        return sub ? (xe - ye) : (xe + ye);
    endfunction

    function automatic logic addsub_ovf(input logic [DATA_W-1:0] x,
                                        input logic [DATA_W-1:0] y,
                                        input logic              sub);
        logic [DATA_W:0] s;
        s = ext_sum(x, y, sub);
        return s[DATA_W] != s[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] addsub(input logic [DATA_W-1:0] x,
                                                 input logic [DATA_W-1:0] y,
                                                 input logic              sub);
        logic [DATA_W:0] s;
        s = ext_sum(x, y, sub);
        // Sign of the (DATA_W+1)-bit true sum picks the clamp direction.
        if (s[DATA_W] != s[DATA_W-1]) begin
            return s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
        return s[DATA_W-1:0];
    endfunction
`else
    function automatic logic [DATA_W-1:0] addsub(input logic [DATA_W-1:0] x,
                                                 input logic [DATA_W-1:0] y,
                                                 input logic              sub);
        return sub ? (x - y) : (x + y);
    endfunction
`endif

    alu_state_e state_q, state_d;

    // Operands captured on accept
    logic [OPC_W-1:0]  opc_q, opc_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [IMM_W-1:0]  imm_q, imm_d;

    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              ov_q, ov_d;
    logic              z_q, z_d;
    logic              n_q, n_d;
    logic              dz_q, dz_d;
`ifdef ALU_SAT_EN
    logic              v_q, v_d;
    logic              sc_v;
    logic              wr_v;
`endif

    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] sc_res;
    logic              sc_dz;
    logic              sc_clr;
    logic              use_add;
    logic              add_sub;
    logic [DATA_W-1:0] add_x;
    logic [DATA_W-1:0] add_y;
    logic [DATA_W:0]   avg_sum;

    logic              wr;
    logic [DATA_W-1:0] wr_res;
    logic              wr_dz;

    logic              accept;
    logic              iter_start;
    logic              iter_div;
    logic              iter_done;
    logic [DATA_W-1:0] iter_res;
    logic [DATA_W-1:0] iter_b;

    assign in_ready = (state_q == StIdle) && (!ov_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q == StMul) || (state_q == StDiv);
    assign imm_ext  = {{(DATA_W-IMM_W){imm_q[IMM_W-1]}}, imm_q};
    assign avg_sum  = {1'b0, a_q} + {1'b0, b_q};
    assign iter_b   = (opcode == OP_SQR) ? op1 : op2;

    alu_iter_muldiv #(
        .DATA_W (DATA_W)
    ) u_iter (
        .clk      (clk),
        .rst      (rst),
        .start    (iter_start),
        .mode_div (iter_div),
        .a        (op1),
        .b        (iter_b),
        .done     (iter_done),
        .res      (iter_res)
    );

    // Single-cycle datapath, evaluated from the captured operands while in StDone.
    always_comb begin
        sc_res  = '0;
        sc_dz   = 1'b0;
        sc_clr  = 1'b0;
        use_add = 1'b0;
        add_sub = 1'b0;
        add_x   = a_q;
        add_y   = b_q;
        case (opc_q)
            OP_ADD:  use_add = 1'b1;
            OP_SUB:  begin use_add = 1'b1; add_sub = 1'b1; end
            OP_INC:  begin use_add = 1'b1; add_y = DATA_W'(1); end
            OP_DEC:  begin use_add = 1'b1; add_sub = 1'b1; add_y = DATA_W'(1); end
            OP_ADDI: begin use_add = 1'b1; add_y = imm_ext; end
            OP_SUBI: begin use_add = 1'b1; add_sub = 1'b1; add_y = imm_ext; end
            OP_AND:  sc_res = a_q & b_q;
            OP_OR:   sc_res = a_q | b_q;
            OP_XOR:  sc_res = a_q ^ b_q;
            OP_NOT:  sc_res = ~a_q;
            OP_ANDI: sc_res = a_q & imm_ext;
            OP_ORI:  sc_res = a_q | imm_ext;
            // Most-negative value negates to itself.
            OP_ABS:  sc_res = a_q[DATA_W-1] ? ('0 - a_q) : a_q;
            OP_AVG:  sc_res = DATA_W'(avg_sum >> 1);
            OP_EQ:   sc_res = DATA_W'(a_q == b_q);
            OP_NE:   sc_res = DATA_W'(a_q != b_q);
            OP_CLRACC: sc_clr = 1'b1;
            // Only a zero divisor reaches StDone with OP_DIV.
            OP_DIV:  begin sc_res = '1; sc_dz = 1'b1; end
            default: sc_res = '0;
        endcase
        if (use_add) begin
            sc_res = addsub(add_x, add_y, add_sub);
        end
    end

`ifdef ALU_SAT_EN
    assign sc_v = use_add && addsub_ovf(add_x, add_y, add_sub);
`endif

    always_comb begin
        state_d    = state_q;
        opc_d      = opc_q;
        a_d        = a_q;
        b_d        = b_q;
        imm_d      = imm_q;
        acc_d      = acc_q;
        res_d      = res_q;
        z_d        = z_q;
        n_d        = n_q;
        dz_d       = dz_q;
        ov_d       = ov_q && !out_ready;
        wr         = 1'b0;
        wr_res     = '0;
        wr_dz      = 1'b0;
        iter_start = 1'b0;
        iter_div   = 1'b0;
`ifdef ALU_SAT_EN
        v_d        = v_q;
        wr_v       = 1'b0;
`endif

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    opc_d = opcode;
                    a_d   = op1;
                    b_d   = op2;
                    imm_d = immediate;
                    if (opcode == OP_MUL || opcode == OP_SQR || opcode == OP_MAC) begin
                        iter_start = 1'b1;
                        state_d    = StMul;
                    end else if (opcode == OP_DIV && op2 != '0) begin
                        iter_start = 1'b1;
                        iter_div   = 1'b1;
                        state_d    = StDiv;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                wr     = 1'b1;
                wr_res = sc_res;
                wr_dz  = sc_dz;
`ifdef ALU_SAT_EN
                wr_v   = sc_v;
`endif
                if (sc_clr) begin
                    acc_d = '0;
                end
                state_d = StIdle;
            end
            StMul: begin
                if (iter_done) begin
                    wr = 1'b1;
                    if (opc_q == OP_MAC) begin
                        wr_res = addsub(acc_q, iter_res, 1'b0);
                        acc_d  = wr_res;
`ifdef ALU_SAT_EN
                        wr_v   = addsub_ovf(acc_q, iter_res, 1'b0);
`endif
                    end else begin
                        wr_res = iter_res;
                    end
                    state_d = StIdle;
                end
            end
            StDiv: begin
                if (iter_done) begin
                    wr      = 1'b1;
                    wr_res  = iter_res;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (wr) begin
            ov_d  = 1'b1;
            res_d = wr_res;
            z_d   = (wr_res == '0);
            n_d   = wr_res[DATA_W-1];
            dz_d  = wr_dz;
`ifdef ALU_SAT_EN
            v_d   = wr_v;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            opc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            ov_q    <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            dz_q    <= 1'b0;
`ifdef ALU_SAT_EN
            v_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            ov_q    <= ov_d;
            z_q     <= z_d;
            n_q     <= n_d;
            dz_q    <= dz_d;
`ifdef ALU_SAT_EN
            v_q     <= v_d;
`endif
        end
    end

    assign out_valid = ov_q;
    assign result    = res_q;
    assign flag_z    = z_q;
    assign flag_n    = n_q;
    assign flag_dz   = dz_q;
`ifdef ALU_SAT_EN
    assign flag_v    = v_q;
`endif

endmodule
